// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU source, LSU/MUL handshake source, register-file write port
// and hazard/occupancy exports.
interface wb_arbiter_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH    = 4
);
  localparam int unsigned CountWidth = $clog2(FIFO_DEPTH) + 1;

  logic                          a_valid;
  logic [ADDRESS_WIDTH-1:0]      a_rd;
  logic [DATA_WIDTH-1:0]         a_data;
  logic                          b_valid;
  logic                          b_ready;
  logic [ADDRESS_WIDTH-1:0]      b_rd;
  logic [DATA_WIDTH-1:0]         b_data;
  logic                          we;
  logic [ADDRESS_WIDTH-1:0]      A3;
  logic [DATA_WIDTH-1:0]         WD;
  logic                          stall_req;
  logic [(1<<ADDRESS_WIDTH)-1:0] pending;
  logic [CountWidth-1:0]         fifo_count;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  b_ready, we, A3, WD, stall_req, pending, fifo_count
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output b_ready, we, A3, WD, stall_req, pending, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results win the register-file port, LSU/MUL results queue in a
// small FIFO and drain into idle slots, with a periodic stall request against starvation.
module wb_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input logic         clk,
  input logic         res,
  wb_arbiter_if.slave bus
);
  localparam int unsigned PtrWidth    = $clog2(FIFO_DEPTH);
  localparam int unsigned CountWidth  = PtrWidth + 1;
  localparam int unsigned StarveWidth = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NumRegs     = 1 << ADDRESS_WIDTH;

  logic [ADDRESS_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [FIFO_DEPTH];

  logic [PtrWidth-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CountWidth-1:0]    count_q, count_d;
  logic [StarveWidth-1:0]   starve_q, starve_d;
  logic                     stall_q, stall_d;
  logic                     ready_en_q;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] a3_q;
  logic [DATA_WIDTH-1:0]    wd_q;
  logic [NumRegs-1:0]       pending_d;
  logic [PtrWidth-1:0]      offset;

  logic a_writes, fifo_empty, pop, accept, push;

  assign a_writes   = bus.a_valid && (bus.a_rd != '0);
  assign fifo_empty = (count_q == '0);
  assign pop        = !a_writes && !fifo_empty;
  // Held low until the first edge after reset so no handshake lands during release.
  assign bus.b_ready = ready_en_q && (count_q < CountWidth'(FIFO_DEPTH));
  assign accept      = bus.b_valid && bus.b_ready;
  assign push        = accept && (bus.b_rd != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A cycle is "blocked" when the FIFO holds data but nothing pops.
  always_comb begin
    starve_d = '0;
    stall_d  = 1'b0;
    if (!fifo_empty && !pop) begin
      if (starve_q == StarveWidth'(STARVE_LIMIT)) begin
        stall_d = 1'b1;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_comb begin
    pending_d = '0;
    offset    = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      offset = PtrWidth'(i) - rd_ptr_q;
      if ({1'b0, offset} < count_q) begin
        pending_d[rd_mem[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= bus.b_rd;
      data_mem[wr_ptr_q] <= bus.b_data;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      ready_en_q <= 1'b0;
      we_q       <= 1'b0;
      a3_q       <= '0;
      wd_q       <= '0;
    end else begin
      ready_en_q <= 1'b1;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      we_q       <= a_writes || pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (a_writes) begin
        a3_q <= bus.a_rd;
        wd_q <= bus.a_data;
      end else if (pop) begin
        a3_q <= rd_mem[rd_ptr_q];
        wd_q <= data_mem[rd_ptr_q];
      end
    end
  end

  assign bus.we         = we_q;
  assign bus.A3         = a3_q;
  assign bus.WD         = wd_q;
  assign bus.stall_req  = stall_q;
  assign bus.pending    = pending_d;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based model of the write-back rules.
module tb_wb_arbiter;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;

  logic clk;
  logic res;

  wb_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

  wb_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic          m_we, m_stall, m_ready_en;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd;
  int            streak;
  int            n_vec, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_a3 = '0; m_wd = '0; m_stall = 1'b0; m_ready_en = 1'b0; streak = 0;
  endtask

  task automatic compare_all();
    logic [31:0] pend;
    pend = '0;
    foreach (q[i]) pend[q[i].rd] = 1'b1;
    check("we", 64'(bus.we), 64'(m_we));
    check("A3", 64'(bus.A3), 64'(m_a3));
    check("WD", 64'(bus.WD), 64'(m_wd));
    check("stall_req", 64'(bus.stall_req), 64'(m_stall));
    check("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
    check("pending", 64'(bus.pending), 64'(pend));
    check("b_ready", 64'(bus.b_ready), 64'(m_ready_en && (q.size() < DEPTH)));
  endtask

  // Apply current inputs across one rising edge, advancing the model alongside.
  task automatic tick();
    bit            aw, pop, rdy, n_we, n_stall;
    logic [AW-1:0] n_a3;
    logic [DW-1:0] n_wd;
    aw   = bus.a_valid && (bus.a_rd != 0);
    rdy  = m_ready_en && (q.size() < DEPTH);
    pop  = !aw && (q.size() > 0);
    n_we = aw || pop;
    n_a3 = m_a3; n_wd = m_wd;
    if (aw) begin
      n_a3 = bus.a_rd; n_wd = bus.a_data;
    end else if (pop) begin
      n_a3 = q[0].rd; n_wd = q[0].d;
    end
    n_stall = 1'b0;
    if (q.size() > 0 && !pop) begin
      if (streak == LIMIT) begin
        n_stall = 1'b1; streak = 0;
      end else begin
        streak++;
      end
    end else begin
      streak = 0;
    end
    if (pop) void'(q.pop_front());
    if (bus.b_valid && rdy && bus.b_rd != 0) q.push_back('{rd: bus.b_rd, d: bus.b_data});
    @(posedge clk);
    #1;
    m_we = n_we; m_a3 = n_a3; m_wd = n_wd; m_stall = n_stall; m_ready_en = 1'b1;
    compare_all();
  endtask

  task automatic set_a(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.a_valid = v; bus.a_rd = rd; bus.a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.b_valid = v; bus.b_rd = rd; bus.b_data = d;
  endtask

  task automatic drain();
    set_a(1'b0, '0, '0); set_b(1'b0, '0, '0);
    for (int k = 0; k < 20 && bus.fifo_count != 0; k++) tick();
    check("drain_empty", 64'(bus.fifo_count), 64'd0);
  endtask

  initial begin
    int lat;
    bit found;
    n_vec = 0; n_err = 0;
    res = 1'b1;
    set_a(1'b0, '0, '0); set_b(1'b0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 res = 1'b0;
    compare_all();
    tick();

    // ALU-only writes, then a_rd=0 idles the slot
    set_a(1'b1, 5'd5, 32'hDEAD_BEEF); tick();
    check("a_only_A3", 64'(bus.A3), 64'd5);
    check("a_only_WD", 64'(bus.WD), 64'hDEAD_BEEF);
    set_a(1'b1, 5'd0, 32'h1234_5678); tick();
    check("a_rd0_we", 64'(bus.we), 64'd0);
    set_a(1'b0, '0, '0); tick();

    // Source-B drain with A idle
    set_b(1'b1, 5'd3, 32'h11); tick();
    set_b(1'b1, 5'd7, 32'h22); tick();
    check("drain_pend7", 64'(bus.pending[7]), 64'd1);
    set_b(1'b0, '0, '0); tick();
    check("drain_rd7", 64'(bus.A3), 64'd7);
    tick();

    // Reset asserted between edges with three entries queued
    set_a(1'b1, 5'd9, 32'hA5A5_0000);
    for (int k = 0; k < 3; k++) begin
      set_b(1'b1, AW'(10 + k), DW'(32'h100 + k)); tick();
    end
    set_b(1'b0, '0, '0);
    check("pre_reset_count", 64'(bus.fifo_count), 64'd3);
    #2 res = 1'b1;
    model_reset();
    #1 compare_all();
    #3 res = 1'b0;
    set_a(1'b0, '0, '0);
    tick();
    check("post_reset_ready", 64'(bus.b_ready), 64'd1);

    // Fill the FIFO while A holds the port every cycle
    set_a(1'b1, 5'd1, 32'hF00D);
    for (int k = 0; k < 6; k++) begin
      set_b(1'b1, AW'(20 + k), DW'($urandom)); tick();
    end
    check("full_count", 64'(bus.fifo_count), 64'd4);
    check("full_ready", 64'(bus.b_ready), 64'd0);
    set_a(1'b0, '0, '0);
    for (int k = 0; k < 3; k++) tick();
    drain();

    // Starvation: one queued entry, A writes continuously
    set_a(1'b1, 5'd9, DW'($urandom)); set_b(1'b1, 5'd12, 32'h77); tick();
    set_b(1'b0, '0, '0);
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      set_a(1'b1, 5'd9, DW'($urandom)); tick();
      if (bus.stall_req) begin
        found = 1'b1; lat = k;
      end
    end
    check("stall_latency", 64'(lat), 64'(LIMIT + 1));
    set_a(1'b0, '0, '0); tick();
    check("stall_drain_we", 64'(bus.we), 64'd1);
    check("stall_drain_rd", 64'(bus.A3), 64'd12);
    drain();

    // b_rd=0 handshakes but is not stored
    set_b(1'b1, 5'd0, 32'hBAD); tick();
    check("rd0_count", 64'(bus.fifo_count), 64'd0);

    // Push and pop together at count 2, wrapping the pointers
    set_a(1'b1, 5'd2, 32'h5); set_b(1'b1, 5'd4, 32'h40); tick();
    set_b(1'b1, 5'd6, 32'h60); tick();
    set_a(1'b0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      set_b(1'b1, AW'(1 + ($urandom % 31)), DW'($urandom)); tick();
      check("pp_count", 64'(bus.fifo_count), 64'd2);
    end
    drain();

    // Random traffic; stall_req is mostly honoured by the stimulus
    for (int k = 0; k < 500; k++) begin
      set_a((($urandom % 3) != 0) && (!bus.stall_req || (($urandom % 8) == 0)),
            AW'($urandom % 8), DW'($urandom));
      set_b(($urandom % 2) == 0, AW'($urandom % 8), DW'($urandom));
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
